// File: rtl/serial_shifter.sv
// Iterative SLL/SRL/SRA shifter, STEP bits per clock, start/done responder.
// Build option SERIAL_SHIFTER_ROTR_EN turns op=11 into ROTR; otherwise op=11 is SLL.
module serial_shifter #(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] data,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic        ovf
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] STEP_C = CW'(STEP);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [1:0]      op_q;
    logic [DW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic            load_c;
    logic            step_c;
    logic            finish_c;
    logic [CW-1:0]   k_c;
    logic [DW-1:0]   acc_shift_c;
`ifdef SERIAL_SHIFTER_ROTR_EN
    logic [2*DW-1:0] rot_c;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nx = state;
        load_c   = 1'b0;
        step_c   = 1'b0;
        finish_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_c   = 1'b1;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt != '0) begin
                    step_c = 1'b1;
                end else begin
                    finish_c = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // One step: shift by min(STEP, cnt) so the final partial step lands exactly on shamt
    always_comb begin
        k_c = (cnt < STEP_C) ? cnt : STEP_C;
`ifdef SERIAL_SHIFTER_ROTR_EN
        rot_c = {acc, acc} >> k_c;
`endif
        case (op_q)
            OP_SLL:  acc_shift_c = acc << k_c;
            OP_SRL:  acc_shift_c = acc >> k_c;
            OP_SRA:  acc_shift_c = DW'($signed(acc) >>> k_c);
`ifdef SERIAL_SHIFTER_ROTR_EN
            default: acc_shift_c = rot_c[DW-1:0];
`else
            default: acc_shift_c = acc << k_c;
`endif
        endcase
    end

    // Operand latch, iteration and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (load_c) begin
                op_q <= op;
                acc  <= data;
                cnt  <= shamt;
            end else if (step_c) begin
                acc <= acc_shift_c;
                cnt <= cnt - k_c;
            end
            if (finish_c) begin
                result <= acc;
                zero   <= (acc == '0);
            end
            // done trails the DONE state by one cycle; busy stays up through that pulse
            done <= (state == S_DONE);
            busy <= (state_nx != S_IDLE) || (state == S_DONE);
        end
    end

    assign ovf = 1'b0;

endmodule

// File: tb/tb_serial_shifter.sv
// Randomized self-checking bench for serial_shifter against a behavioural shift model.
module tb_serial_shifter;

    parameter int unsigned STEP = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] data = '0;
    logic [4:0]  shamt = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic [31:0] exp_res  = '0;
    logic        exp_zero = 1'b0;

    serial_shifter #(.STEP(STEP)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .data(data), .shamt(shamt),
        .busy(busy), .done(done), .result(result), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Whole-shift reference: the iterative unit must equal a single shift by shamt
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        case (o)
            2'b00: return d << s;
            2'b01: return d >> s;
            2'b10: return 32'($signed(d) >>> s);
`ifdef SERIAL_SHIFTER_ROTR_EN
            default: return (s == 0) ? d : ((d >> s) | (d << (32 - int'(s))));
`else
            default: return d << s;
`endif
        endcase
    endfunction

    function automatic int latency(input logic [4:0] s);
        return (int'(s) + int'(STEP) - 1) / int'(STEP) + 2;
    endfunction

    // Per-cycle compare against the expected timeline
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("ovf", 32'(ovf), 32'h0);
            if (exp_done || !exp_busy) begin
                chk("result", result, exp_res);
                chk("zero", 32'(zero), 32'(exp_zero));
            end
        end
    end

    task automatic do_req(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                          input bit glitch, output int meas, output logic [31:0] got);
        int lat;
        logic [31:0] want;
        lat  = latency(s);
        want = model(o, d, s);
        meas = -1;
        got  = 'x;
        @(negedge clk);
        op = o; data = d; shamt = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom); data = $urandom; shamt = 5'($urandom);
        exp_busy = 1'b1;
        exp_done = 1'b0;
        if (glitch) begin
            start = 1'b1;
            data  = 32'hFFFF_FFFF;
        end
        for (int e = 1; e <= lat; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done && meas < 0) begin
                meas = e;
                got  = result;
            end
            if (e == lat) begin
                exp_done = 1'b1;
                exp_res  = want;
                exp_zero = (want == 32'h0);
            end
        end
        @(posedge clk);
        #1;
        exp_busy = 1'b0;
        exp_done = 1'b0;
    endtask

    int          meas;
    logic [31:0] got;

    initial begin
        #23;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        do_req(2'b00, 32'h0000_0001, 5'd31, 1'b0, meas, got);
        chk("sll31_result", got, 32'h8000_0000);

        do_req(2'b10, 32'h8000_0000, 5'd4, 1'b0, meas, got);
        chk("sra4_result", got, 32'hF800_0000);
        do_req(2'b01, 32'h8000_0000, 5'd4, 1'b0, meas, got);
        chk("srl4_result", got, 32'h0800_0000);

        do_req(2'b01, 32'h0000_0000, 5'd0, 1'b0, meas, got);
        chk("shamt0_latency", 32'(meas), 32'd2);
        chk("shamt0_zero", 32'(zero), 32'd1);
        do_req(2'b00, 32'h1234_ABCD, 5'd0, 1'b0, meas, got);
        chk("shamt0_passthru", got, 32'h1234_ABCD);

        do_req(2'b00, 32'h0000_0001, 5'd8, 1'b1, meas, got);
        chk("busy_ignore_result", got, 32'h0000_0100);
        do_req(2'b01, 32'hF000_000F, 5'd3, 1'b0, meas, got);
        chk("after_ignore_result", got, 32'h1E00_0001);

        do_req(2'b11, 32'h0000_0001, 5'd1, 1'b0, meas, got);
`ifdef SERIAL_SHIFTER_ROTR_EN
        chk("op11_result", got, 32'h8000_0000);
`else
        chk("op11_result", got, 32'h0000_0002);
`endif

        // Reset in the middle of a shift clears outputs without waiting for a clock
        @(negedge clk);
        op = 2'b00; data = 32'hDEAD_BEEF; shamt = 5'd20; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_busy = 1'b1;
        exp_done = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", 32'(zero), 32'h0);
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_res  = '0;
        exp_zero = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        do_req(2'b10, 32'h4000_0000, 5'd2, 1'b0, meas, got);
        chk("post_rst_result", got, 32'h1000_0000);

        for (int i = 0; i < 40; i++) begin
            do_req(2'($urandom), $urandom, 5'($urandom), 1'($urandom), meas, got);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
